// File: rtl/uart_hex_tx_ctrl.sv
// uart_hex_tx_ctrl: sends a snapshot of x as 4 ASCII hex chars (+ optional CR LF) over the uart_tx tdre/ready handshake; in: clk clr go x tdre, out: ready tx_data busy done
module uart_hex_tx_ctrl #(
  parameter bit EOL = 1'b1,
  parameter bit UPPER = 1'b1,
  parameter int ACK_TO = 16
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        go,
  input  logic [15:0] x,
  input  logic        tdre,
  output logic        ready,
  output logic [7:0]  tx_data,
  output logic        busy,
  output logic        done
);
  localparam logic [2:0] LAST = EOL ? 3'd5 : 3'd3;
  localparam int CW = $clog2(ACK_TO + 1);
  typedef enum logic [2:0] {IDLE, LOAD, WAIT_RDY, WAIT_ACK, WAIT_DONE, FINISH} state_t;
  state_t r_state;
  logic r_go_q, r_arm;
  logic [15:0] r_x;
  logic [2:0] r_idx;
  logic [CW-1:0] r_cnt;
  logic [3:0] w_nib;
  logic [7:0] w_byte;
  logic w_start;
  always_comb begin
    w_nib = r_idx == 3'd0 ? r_x[15:12] : r_idx == 3'd1 ? r_x[11:8] : r_idx == 3'd2 ? r_x[7:4] : r_x[3:0];
    w_byte = r_idx == 3'd4 ? 8'h0d : r_idx == 3'd5 ? 8'h0a :
             w_nib <= 4'd9 ? 8'h30 + {4'h0, w_nib} : (UPPER ? 8'h37 : 8'h57) + {4'h0, w_nib};
  end
  assign w_start = go & ~r_go_q & r_arm;
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= IDLE;
      r_go_q <= 1'b0;
      r_arm <= 1'b0;
      r_x <= '0;
      r_idx <= '0;
      r_cnt <= '0;
      ready <= 1'b0;
      tx_data <= 8'h00;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      r_go_q <= go;
      r_arm <= r_arm | ~go;
      ready <= 1'b0;
      done <= 1'b0;
      case (r_state)
        IDLE: if (w_start) begin
          r_x <= x;
          r_idx <= '0;
          busy <= 1'b1;
          r_state <= LOAD;
        end
        LOAD: begin
          tx_data <= w_byte;
          r_state <= WAIT_RDY;
        end
        WAIT_RDY: if (tdre) begin
          ready <= 1'b1;
          r_cnt <= '0;
          r_state <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (!tdre) r_state <= WAIT_DONE;
          else if (r_cnt == CW'(ACK_TO - 1)) r_state <= WAIT_RDY;
          else r_cnt <= r_cnt + 1'b1;
        end
        WAIT_DONE: if (tdre) begin
          if (r_idx == LAST) begin
            done <= 1'b1;
            r_state <= FINISH;
          end else begin
            r_idx <= r_idx + 3'd1;
            r_state <= LOAD;
          end
        end
        FINISH: begin
          busy <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_hex_tx_ctrl.sv
// tb_uart_hex_tx_ctrl: scoreboard bench for uart_hex_tx_ctrl with a behavioural uart_tx model
module tb_uart_hex_tx_ctrl;
  localparam int ACK_TO = 16;
  logic clk = 1'b0;
  logic clr = 1'b1;
  logic go [2];
  logic tdre [2];
  logic ready [2];
  logic busy [2];
  logic done [2];
  logic [15:0] x [2];
  logic [7:0] txd [2];
  logic [7:0] sbq [$];
  logic [7:0] m_exp, ign_byte;
  int vectors = 0, errors = 0, cyc = 0;
  int np [2], nd [2], acc [2], bc [2];
  int ignore = 0, ign_cyc = 0, lat, hi, n0;
  bit retry = 0;
  always #20 clk = ~clk;
  always @(posedge clk) cyc++;
  uart_hex_tx_ctrl #(.EOL(1'b1), .UPPER(1'b1), .ACK_TO(ACK_TO)) u_a (
    .clk(clk), .clr(clr), .go(go[0]), .x(x[0]), .tdre(tdre[0]),
    .ready(ready[0]), .tx_data(txd[0]), .busy(busy[0]), .done(done[0])
  );
  uart_hex_tx_ctrl #(.EOL(1'b0), .UPPER(1'b0), .ACK_TO(ACK_TO)) u_b (
    .clk(clk), .clr(clr), .go(go[1]), .x(x[1]), .tdre(tdre[1]),
    .ready(ready[1]), .tx_data(txd[1]), .busy(busy[1]), .done(done[1])
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] hexc(input logic [3:0] n, input bit up);
    string s;
    s = up ? "0123456789ABCDEF" : "0123456789abcdef";
    return s[n];
  endfunction
  task automatic push(input logic [15:0] v, input bit up, input bit eol);
    for (int k = 3; k >= 0; k--) sbq.push_back(hexc(v[4*k+:4], up));
    if (eol) begin
      sbq.push_back(8'h0d);
      sbq.push_back(8'h0a);
    end
  endtask
  task automatic clr_cnt(input int i);
    np[i] = 0;
    nd[i] = 0;
    acc[i] = 0;
  endtask
  task automatic send(input int i, input logic [15:0] v, input bit up, input bit eol);
    push(v, up, eol);
    @(negedge clk);
    x[i] = v;
    go[i] = 1'b1;
    @(negedge clk);
    go[i] = 1'b0;
  endtask
  task automatic wait_done(input int i, input int lim);
    int k = 0;
    while (nd[i] == 0 && k < lim) begin
      @(negedge clk);
      k++;
    end
    check("done_wait", nd[i] > 0, 1);
  endtask
  task automatic finish_checks(input string tag, input int i, input int pulses);
    repeat (3) @(negedge clk);
    check({tag, "_pulses"}, np[i], pulses);
    check({tag, "_done"}, nd[i], 1);
    check({tag, "_busy"}, busy[i], 0);
    check({tag, "_sb"}, sbq.size(), 0);
  endtask
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (done[i]) nd[i]++;
      if (ready[i]) begin
        np[i]++;
        check("rdy_tdre", tdre[i], 1);
        if (retry) begin
          check("retry_byte", txd[i], ign_byte);
          check("retry_gap", (cyc - ign_cyc) >= ACK_TO && (cyc - ign_cyc) <= ACK_TO + 2, 1);
          retry = 0;
        end
        if (ignore > 0) begin
          ignore--;
          ign_byte = txd[i];
          ign_cyc = cyc;
          retry = 1;
        end else begin
          m_exp = 8'h00;
          if (sbq.size() > 0) m_exp = sbq.pop_front();
          check("byte", txd[i], m_exp);
          tdre[i] = 1'b0;
          bc[i] = 4;
          acc[i]++;
        end
      end else if (!tdre[i] && bc[i] > 0) begin
        bc[i]--;
        if (bc[i] == 0) tdre[i] = 1'b1;
      end
    end
  end
  initial begin
    for (int i = 0; i < 2; i++) begin
      go[i] = 1'b0;
      tdre[i] = 1'b1;
      x[i] = '0;
      bc[i] = 0;
      clr_cnt(i);
    end
    repeat (3) @(negedge clk);
    check("rst_ready", ready[0], 0);
    check("rst_txd", txd[0], 0);
    check("rst_busy", busy[0], 0);
    check("rst_done", done[0], 0);
    clr = 1'b0;
    @(negedge clk);
    foreach (sbq[k]) sbq.delete(k);
    sbq.push_back(8'h31);
    sbq.push_back(8'h32);
    sbq.push_back(8'h41);
    sbq.push_back(8'h42);
    sbq.push_back(8'h0d);
    sbq.push_back(8'h0a);
    x[0] = 16'h12AB;
    go[0] = 1'b1;
    lat = 0;
    for (int k = 1; k <= 10 && lat == 0; k++) begin
      @(negedge clk);
      if (k == 1) check("busy_rise", busy[0], 1);
      if (ready[0]) lat = k;
    end
    go[0] = 1'b0;
    check("latency", lat, 3);
    wait_done(0, 500);
    finish_checks("t1", 0, 6);
    clr_cnt(1);
    send(1, 16'hF00D, 1'b0, 1'b0);
    wait_done(1, 500);
    finish_checks("t2", 1, 4);
    @(negedge clk);
    tdre[0] = 1'b0;
    clr_cnt(0);
    send(0, 16'hBEEF, 1'b1, 1'b1);
    hi = 0;
    repeat (100) begin
      @(negedge clk);
      if (ready[0]) hi++;
    end
    check("t3_quiet", hi, 0);
    check("t3_busy", busy[0], 1);
    tdre[0] = 1'b1;
    @(negedge clk);
    check("t3_rdy", ready[0], 1);
    @(negedge clk);
    check("t3_rdy_once", ready[0], 0);
    wait_done(0, 500);
    finish_checks("t3", 0, 6);
    clr_cnt(0);
    push(16'h5A3C, 1'b1, 1'b1);
    @(negedge clk);
    x[0] = 16'h5A3C;
    go[0] = 1'b1;
    repeat (20) @(negedge clk);
    x[0] = 16'hFFFF;
    go[0] = 1'b0;
    repeat (3) @(negedge clk);
    check("t4_busy_mid", busy[0], 1);
    go[0] = 1'b1;
    wait_done(0, 500);
    repeat (40) @(negedge clk);
    finish_checks("t4", 0, 6);
    go[0] = 1'b0;
    clr_cnt(0);
    send(0, 16'h0789, 1'b1, 1'b1);
    wait_done(0, 500);
    finish_checks("t4b", 0, 6);
    clr_cnt(0);
    ignore = 1;
    send(0, 16'hC0DE, 1'b1, 1'b1);
    wait_done(0, 1000);
    finish_checks("t5", 0, 7);
    check("t5_retry", retry, 0);
    clr_cnt(0);
    send(0, 16'h4321, 1'b1, 1'b1);
    hi = 0;
    while (acc[0] < 3 && hi < 500) begin
      @(negedge clk);
      hi++;
    end
    check("t6_three", acc[0] >= 3, 1);
    @(negedge clk);
    clr = 1'b1;
    go[0] = 1'b1;
    @(negedge clk);
    check("t6_ready", ready[0], 0);
    check("t6_busy", busy[0], 0);
    check("t6_txd", txd[0], 0);
    check("t6_done", done[0], 0);
    sbq.delete();
    n0 = np[0];
    @(negedge clk);
    clr = 1'b0;
    repeat (30) @(negedge clk);
    check("t6_no_start", busy[0], 0);
    check("t6_no_pulse", np[0], n0);
    go[0] = 1'b0;
    clr_cnt(0);
    send(0, 16'h4321, 1'b1, 1'b1);
    wait_done(0, 500);
    finish_checks("t6", 0, 6);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/uart_hex_tx_ctrl.md
Name: uart_hex_tx_ctrl

Overview:
Sequencer that drives the uart_tx byte transmitter. On a rising edge of a debounced go button it snapshots a 16-bit value and transmits it as 4 ASCII hex characters, MS nibble first, optionally followed by CR LF. It feeds uart_tx through the tdre/ready handshake, replacing test_tx_ctrl in the top level. It runs on the 25 MHz UART clock.

Parameters:
EOL, 1, 1 = append 0x0D 0x0A after the hex digits (6 bytes total); 0 = 4 bytes only
UPPER, 1, 1 = hex letters A-F as 0x41-0x46; 0 = a-f as 0x61-0x66
ACK_TO, 16, number of cycles to wait for tdre to fall after a ready pulse before the same byte is re-issued

Ports:
clk  in  1  system clock (clk25 domain)
clr  in  1  synchronous reset, active-high
go  in  1  debounced button level; a rising edge starts one message
x  in  16  value to transmit; sampled only at message start
tdre  in  1  from uart_tx: 1 = transmit data register empty / able to accept a byte
ready  out  1  to uart_tx: one-cycle load strobe for tx_data
tx_data  out  8  byte presented to uart_tx; stable whenever ready=1
busy  out  1  high from message start until the last byte completes
done  out  1  one-cycle pulse when the last byte has completed

Behaviour:
- Synchronous reset, active-high: all state is set on the clk edge while clr=1. Reset values: ready=0, tx_data=0x00, busy=0, done=0, state=IDLE, go_q=0, char index=0. Reset mid-message abandons the message immediately; no further ready pulses are issued.
- Edge detect: go_q is registered from go each cycle. start = go & ~go_q, evaluated only in IDLE. Edges while busy=1 are ignored and not queued. If go is already high when reset is released, no start occurs until go falls and rises again.
- Message bytes (index 0..N-1, N = 4 + 2*EOL):
  - hex(x_s[15:12]), hex(x_s[11:8]), hex(x_s[7:4]), hex(x_s[3:0]), then 0x0D, 0x0A.
  - hex(n) = 0x30+n for n<=9. For n>=10: 0x37+n when UPPER=1, 0x57+n when UPPER=0.
- States:
  - IDLE: busy=0. On start, latch x_s <= x, index <= 0, go to LOAD. busy=1 from the next cycle.
  - LOAD: tx_data <= byte(index). Go to WAIT_RDY.
  - WAIT_RDY: when tdre=1, assert ready for exactly 1 cycle and go to WAIT_ACK.
  - WAIT_ACK: wait for tdre=0, then go to WAIT_DONE. If tdre stays 1 for ACK_TO consecutive cycles, return to WAIT_RDY and re-pulse the same byte (retry, no limit).
  - WAIT_DONE: wait for tdre=1. If index = N-1, go to FINISH; otherwise index++ and go to LOAD.
  - FINISH: done=1 for 1 cycle, busy=0 from the next cycle, return to IDLE.
- tx_data is held constant from LOAD until the next LOAD. ready is never asserted while tdre=0.
- Latency: start-edge cycle = c. LOAD at c+1. With tdre=1, the first ready pulse is at c+2.
- Changes to x after start have no effect on the message in flight.
- Expected RTL size: 150-250 lines.

Test Plan:
1. EOL=1, UPPER=1, x=0x12AB, pulse go, behavioural uart_tx model -> tx_data sequence at each ready pulse is 0x31,0x32,0x41,0x42,0x0D,0x0A; exactly 6 ready pulses; one done pulse; busy then drops.
2. UPPER=0, EOL=0, x=0xF00D -> bytes 0x66,0x30,0x30,0x64; 4 ready pulses.
3. tdre held low 100 cycles after start -> ready stays 0 throughout. When tdre rises at cycle t, ready=1 at t+1 only.
4. go held high through the message, plus a second go edge mid-message -> exactly one message sent. A new edge after done starts a second message.
5. Model ignores the first ready (tdre stays 1) -> after ACK_TO=16 cycles the same byte is re-pulsed. Completed byte stream is unchanged.
6. clr asserted after the 3rd byte -> next cycle ready=0, busy=0, tx_data=0x00, state IDLE. A fresh go sends the full message from byte 0.
